sv_input_streamer: RTL and testbench



---
 rtl/sv_input_streamer.sv | 161 ++++++++++++++++
 tb/tb_sv_input_streamer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sv_input_streamer.sv
// Streams packed int8 activations from a 32-bit BRAM read port onto an AXI-Stream master, one byte per beat.
// Build option: define INSTREAM_SIGN_EXT_EN to sign-extend each byte into TDATA; otherwise it is zero-extended.
module sv_input_streamer #(
    parameter int DATA_WIDTH      = 32,
    parameter int BRAM_DATA_WIDTH = 32,
    parameter int ADDR_WIDTH      = 32,
    parameter int C_TID_WIDTH     = 2,
    parameter int NUM_LANES       = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [ADDR_WIDTH-1:0]        base_offset,
    input  logic [ADDR_WIDTH-1:0]        num_elements,
    output logic                         busy,
    output logic                         done,
    output logic                         M_AXIS_TVALID,
    input  logic                         M_AXIS_TREADY,
    output logic [DATA_WIDTH-1:0]        M_AXIS_TDATA,
    output logic                         M_AXIS_TLAST,
    output logic [C_TID_WIDTH-1:0]       M_AXIS_TID,
    output logic [31:0]                  BRAM_addr,
    output logic [BRAM_DATA_WIDTH-1:0]   BRAM_din,
    input  logic [BRAM_DATA_WIDTH-1:0]   BRAM_dout,
    output logic                         BRAM_en,
    output logic [BRAM_DATA_WIDTH/8-1:0] BRAM_we,
    output logic                         BRAM_rst,
    output logic                         BRAM_clk,
    output logic [2:0]                   dbg_state_o
);

    // AXI-Stream handshake: a beat transfers on a rising clk edge where TVALID and TREADY are both high;
    // TVALID/TDATA/TLAST/TID are registers that hold until that edge and never look at TREADY combinationally.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_LATCH  = 3'd2,
        S_STREAM = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t                     state_q;
    logic [ADDR_WIDTH-1:0]      byte_idx_q;
    logic [ADDR_WIDTH-1:0]      remaining_q;
    logic [BRAM_DATA_WIDTH-1:0] word_buf_q;
    logic                       busy_q;
    logic                       done_q;
    logic                       tvalid_q;
    logic                       tlast_q;
    logic                       bram_en_q;
    logic [C_TID_WIDTH-1:0]     tid_q;
    logic [DATA_WIDTH-1:0]      tdata_q;

    logic                       hs;
    logic [ADDR_WIDTH-1:0]      byte_idx_d;
    logic [C_TID_WIDTH-1:0]     tid_d;

    function automatic logic [DATA_WIDTH-1:0] ext(input logic [7:0] b);
`ifdef INSTREAM_SIGN_EXT_EN
        return {{(DATA_WIDTH-8){b[7]}}, b};
`else
        return {{(DATA_WIDTH-8){1'b0}}, b};
`endif
    endfunction

    function automatic logic [7:0] lane_byte(input logic [BRAM_DATA_WIDTH-1:0] w, input logic [1:0] lane);
        return w[{lane, 3'b000} +: 8];
    endfunction

    assign hs         = (state_q == S_STREAM) && tvalid_q && M_AXIS_TREADY;
    assign byte_idx_d = byte_idx_q + ADDR_WIDTH'(1);
    assign tid_d      = (tid_q == C_TID_WIDTH'(NUM_LANES - 1)) ? '0 : tid_q + C_TID_WIDTH'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            byte_idx_q  <= '0;
            remaining_q <= '0;
            word_buf_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            tvalid_q    <= 1'b0;
            tlast_q     <= 1'b0;
            bram_en_q   <= 1'b0;
            tid_q       <= '0;
            tdata_q     <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        busy_q <= 1'b1;
                        if (num_elements != '0) begin
                            byte_idx_q  <= base_offset;
                            remaining_q <= num_elements;
                            tid_q       <= '0;
                            bram_en_q   <= 1'b1;
                            state_q     <= S_FETCH;
                        end else begin
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end
                    end
                end
                S_FETCH: begin
                    bram_en_q <= 1'b0;
                    state_q   <= S_LATCH;
                end
                S_LATCH: begin
                    // Read data arrives one cycle after the enable, so the first beat is built straight from it.
                    word_buf_q <= BRAM_dout;
                    tdata_q    <= ext(lane_byte(BRAM_dout, byte_idx_q[1:0]));
                    tvalid_q   <= 1'b1;
                    tlast_q    <= (remaining_q == ADDR_WIDTH'(1));
                    state_q    <= S_STREAM;
                end
                S_STREAM: begin
                    if (hs) begin
                        byte_idx_q  <= byte_idx_d;
                        remaining_q <= remaining_q - ADDR_WIDTH'(1);
                        tid_q       <= tid_d;
                        if (remaining_q == ADDR_WIDTH'(1)) begin
                            tvalid_q <= 1'b0;
                            tlast_q  <= 1'b0;
                            done_q   <= 1'b1;
                            state_q  <= S_DONE;
                        end else if (byte_idx_q[1:0] == 2'd3) begin
                            tvalid_q  <= 1'b0;
                            tlast_q   <= 1'b0;
                            bram_en_q <= 1'b1;
                            state_q   <= S_FETCH;
                        end else begin
                            tdata_q <= ext(lane_byte(word_buf_q, byte_idx_d[1:0]));
                            tlast_q <= (remaining_q == ADDR_WIDTH'(2));
                        end
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign M_AXIS_TVALID = tvalid_q;
    assign M_AXIS_TDATA  = tdata_q;
    assign M_AXIS_TLAST  = tlast_q;
    assign M_AXIS_TID    = tid_q;
    assign BRAM_addr     = 32'({byte_idx_q[ADDR_WIDTH-1:2], 2'b00});
    assign BRAM_din      = '0;
    assign BRAM_en       = bram_en_q;
    assign BRAM_we       = '0;
    assign BRAM_rst      = ~rst_n;
    assign BRAM_clk      = clk;
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_sv_input_streamer.sv
// Bench for sv_input_streamer: directed jobs plus randomized jobs, checked against a byte-array stream model.
// Define INSTREAM_SIGN_EXT_EN here as for the RTL to select the sign-extending reference.
module tb_sv_input_streamer;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int TW = 2;
    localparam int NL = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_offset = '0;
    logic [AW-1:0] num_elements = '0;
    logic          busy;
    logic          done;
    logic          tvalid;
    logic          tready = 1'b0;
    logic [DW-1:0] tdata;
    logic          tlast;
    logic [TW-1:0] tid;
    logic [31:0]   bram_addr;
    logic [31:0]   bram_din;
    logic [31:0]   bram_dout = '0;
    logic          bram_en;
    logic [3:0]    bram_we;
    logic          bram_rst;
    logic          bram_clk;
    logic [2:0]    dbg_state;

    sv_input_streamer dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .base_offset(base_offset), .num_elements(num_elements),
        .busy(busy), .done(done),
        .M_AXIS_TVALID(tvalid), .M_AXIS_TREADY(tready), .M_AXIS_TDATA(tdata),
        .M_AXIS_TLAST(tlast), .M_AXIS_TID(tid),
        .BRAM_addr(bram_addr), .BRAM_din(bram_din), .BRAM_dout(bram_dout),
        .BRAM_en(bram_en), .BRAM_we(bram_we), .BRAM_rst(bram_rst), .BRAM_clk(bram_clk),
        .dbg_state_o(dbg_state)
    );

    // ---------------- clock / reset / memory ----------------
    always #5 clk = ~clk;

    logic [31:0] mem [0:63];
    always @(posedge clk) if (bram_en) bram_dout <= mem[bram_addr[7:2]];

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        logic [31:0] w;
        w = mem[a[7:2]];
        return w[a[1:0]*8 +: 8];
    endfunction

    function automatic logic [DW-1:0] ref_ext(input logic [7:0] b);
`ifdef INSTREAM_SIGN_EXT_EN
        return DW'(signed'(b));
`else
        return DW'(b);
`endif
    endfunction

    // beat = {tlast, tid, tdata}
    logic [DW+TW:0] exp_q[$];

    task automatic load_expected(input logic [31:0] base, input int num);
        for (int i = 0; i < num; i++) begin
            logic [31:0] a;
            a = base + 32'(i);
            exp_q.push_back({(i == num - 1), TW'(i % NL), ref_ext(mem_byte(a))});
        end
    endtask

    // ---------------- TREADY driver ----------------
    int rmode = 0;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rmode)
                0:       tready = 1'b1;
                1:       tready = ~tready;
                default: tready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // ---------------- monitor ----------------
    int             cyc = 0;
    int             n_beats = 0;
    int             last_beat_cyc = -1;
    int             first_valid_cyc = -1;
    int             done_cnt = 0;
    int             done_cyc = -1;
    int             en_cnt = 0;
    logic [31:0]    addr_log[$];
    logic           prev_stall = 1'b0;
    logic [DW+TW:0] prev_beat = '0;

    always @(negedge clk) begin
        logic [DW+TW:0] cur;
        logic [DW+TW:0] e;
        cyc++;
        cur = {tlast, tid, tdata};
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_tvalid", 64'(tvalid), 64'd1);
                check("hold_beat", 64'(cur), 64'(prev_beat));
            end
            if (tvalid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (tvalid && tready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 64'(cur), 64'h0);
                end else begin
                    e = exp_q.pop_front();
                    check("beat", 64'(cur), 64'(e));
                end
                n_beats++;
                if (tlast) last_beat_cyc = cyc;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (bram_en) begin
                en_cnt++;
                addr_log.push_back(bram_addr);
            end
            prev_stall = tvalid && !tready;
            prev_beat  = cur;
        end
    end

    // ---------------- job driver ----------------
    task automatic run_job(input logic [31:0] base, input int num, input int mode, input bit poke);
        int t0;
        rmode = mode;
        load_expected(base, num);
        first_valid_cyc = -1;
        last_beat_cyc   = -1;
        done_cnt        = 0;
        done_cyc        = -1;
        en_cnt          = 0;
        addr_log.delete();
        @(posedge clk); #1;
        start = 1'b1; base_offset = base; num_elements = 32'(num);
        @(posedge clk); #1;
        start = 1'b0;
        t0 = cyc;
        @(negedge clk);
        check("busy_after_start", 64'(busy), 64'd1);
        if (poke && num > 0) begin
            @(posedge clk); #1;
            start = 1'b1; base_offset = 32'h55; num_elements = 32'd5;
            @(posedge clk); #1;
            start = 1'b0;
        end
        for (int k = 0; k < 3000 && done_cnt == 0; k++) @(posedge clk);
        if (done_cnt == 0) check("job_timeout", 64'd0, 64'd1);
        repeat (3) @(posedge clk);
        #1;
        check("exp_drained", 64'(exp_q.size()), 64'd0);
        check("done_pulses", 64'(done_cnt), 64'd1);
        check("busy_idle", 64'(busy), 64'd0);
        if (num > 0) begin
            check("first_valid_latency", 64'(first_valid_cyc - t0), 64'd3);
            check("done_after_last", 64'(done_cyc - last_beat_cyc), 64'd1);
        end else begin
            check("zero_no_fetch", 64'(en_cnt), 64'd0);
            check("zero_no_valid", 64'(first_valid_cyc), 64'(-1));
            check("zero_done_latency", 64'(done_cyc - t0), 64'd1);
        end
        exp_q.delete();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        mem[0] = 32'h0403_0201;
        mem[1] = 32'h0807_0605;
        mem[2] = 32'h7F80_FF00;

        #3;
        check("rst_tvalid", 64'(tvalid), 64'd0);
        check("rst_tlast", 64'(tlast), 64'd0);
        check("rst_tid", 64'(tid), 64'd0);
        check("rst_tdata", 64'(tdata), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_bram_en", 64'(bram_en), 64'd0);
        check("rst_bram_rst", 64'(bram_rst), 64'd1);
        check("rst_state", 64'(dbg_state), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        run_job(32'd0, 8, 0, 1'b0);
        run_job(32'd3, 3, 0, 1'b0);
        check("addr_count", 64'(en_cnt), 64'd2);
        if (addr_log.size() == 2) begin
            check("addr_first", 64'(addr_log[0]), 64'h0);
            check("addr_second", 64'(addr_log[1]), 64'h4);
        end else begin
            check("addr_log_size", 64'(addr_log.size()), 64'd2);
        end
        run_job(32'd0, 8, 1, 1'b1);
        run_job(32'd0, 0, 0, 1'b0);
        run_job(32'd8, 4, 2, 1'b0);
        run_job(32'hFFFF_FFFE, 5, 0, 1'b0);

        // reset in the middle of a job, then replay the same job
        rmode = 0;
        n_beats = 0;
        load_expected(32'd0, 8);
        @(posedge clk); #1;
        start = 1'b1; base_offset = 32'd0; num_elements = 32'd8;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 200 && n_beats < 2; k++) begin
            @(posedge clk); #2;
        end
        check("mid_reset_beats", 64'(n_beats), 64'd2);
        rst_n = 1'b0;
        #1;
        check("mid_rst_tvalid", 64'(tvalid), 64'd0);
        check("mid_rst_tlast", 64'(tlast), 64'd0);
        check("mid_rst_tid", 64'(tid), 64'd0);
        check("mid_rst_tdata", 64'(tdata), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_bram_en", 64'(bram_en), 64'd0);
        exp_q.delete();
        en_cnt = 0;
        repeat (3) @(posedge clk);
        check("mid_rst_no_fetch", 64'(en_cnt), 64'd0);
        #1 rst_n = 1'b1;
        run_job(32'd0, 8, 0, 1'b0);

        for (int j = 0; j < 12; j++) begin
            run_job(32'($urandom_range(0, 255)), int'($urandom_range(0, 20)), 2, 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
